// File: rtl/axis_sim_stim_source.sv
// rtl/axis_sim_stim_source.sv - AXI4-Stream deterministic packet burst source
module axis_sim_stim_source #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_SRC_PORT           = 8'h01,
  parameter logic [7:0] C_DST_PORT           = 8'h04
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               start,
  input  logic [15:0]                        cfg_len,
  input  logic [15:0]                        cfg_num_pkts,
  input  logic [7:0]                         cfg_gap,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               busy,
  output logic                               done,
  output logic [7:0]                         counter,
  output logic                               activity_send
);

  localparam int          BPB    = C_M_AXIS_DATA_WIDTH / 8;
  localparam int          NWORDS = C_M_AXIS_DATA_WIDTH / 32;
  localparam logic [16:0] BPB17  = 17'(BPB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]     state;
  logic [15:0]    len_r;
  logic [15:0]    num_r;
  logic [7:0]     gap_r;
  logic [7:0]     gap_cnt;
  logic [15:0]    pkt_seq;
  logic [15:0]    beat;
  logic           valid_r;

  logic [16:0]    num_beats;
  logic [16:0]    rem;
  logic           is_last;
  logic [BPB-1:0] last_strb;
  logic           handshake;

  // Beat-count and last-beat strobe derived from the latched length
  always_comb begin
    num_beats = ({1'b0, len_r} + BPB17 - 17'd1) / BPB17;
    rem       = {1'b0, len_r} % BPB17;
    is_last   = (({1'b0, beat} + 17'd1) == num_beats);
    last_strb = '0;
    for (int i = 0; i < BPB; i++) begin
      last_strb[i] = (rem == 17'd0) || (17'(i) < rem);
    end
  end

  // Beat payload is a pure function of held state, so it stays stable across stalls;
  // everything is forced to zero whenever no beat is offered
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tstrb = '0;
    m_axis_tuser = '0;
    m_axis_tlast = 1'b0;
    if (valid_r) begin
      for (int w = 0; w < NWORDS; w++) begin
        m_axis_tdata[w*32 +: 32] = {pkt_seq, beat};
      end
      m_axis_tstrb       = is_last ? last_strb : '1;
      m_axis_tuser[31:0] = {C_DST_PORT, C_SRC_PORT, len_r};
      m_axis_tlast       = is_last;
    end
  end

  assign m_axis_tvalid = valid_r;
  assign handshake     = valid_r & m_axis_tready;

  // Burst sequencer: IDLE -> SEND <-> GAP -> FIN -> IDLE
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      len_r         <= '0;
      num_r         <= '0;
      gap_r         <= '0;
      gap_cnt       <= '0;
      pkt_seq       <= '0;
      beat          <= '0;
      valid_r       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      counter       <= '0;
      activity_send <= 1'b0;
    end else begin
      done          <= 1'b0;
      activity_send <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_len != 16'd0 && cfg_num_pkts != 16'd0) begin
              len_r   <= cfg_len;
              num_r   <= cfg_num_pkts;
              gap_r   <= cfg_gap;
              pkt_seq <= '0;
              beat    <= '0;
              valid_r <= 1'b1;
              busy    <= 1'b1;
              state   <= S_SEND;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (is_last) begin
              counter       <= counter + 8'd1;
              activity_send <= 1'b1;
              if (pkt_seq + 16'd1 == num_r) begin
                valid_r <= 1'b0;
                state   <= S_FIN;
              end else if (gap_r == 8'd0) begin
                pkt_seq <= pkt_seq + 16'd1;
                beat    <= '0;
              end else begin
                valid_r <= 1'b0;
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end else begin
              beat <= beat + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == gap_r - 8'd1) begin
            pkt_seq <= pkt_seq + 16'd1;
            beat    <= '0;
            valid_r <= 1'b1;
            state   <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
